// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: runs one data-memory transaction at a time,
// stalls the pipeline while it is outstanding and returns aligned,
// zero-extended load data for register writeback.
module mem_stage_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  input  logic                  is_mem_op_i,
  input  logic                  is_load_op_i,
  input  logic                  is_store_op_i,
  input  logic                  is_byte_op_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  output logic                  dmem_req_v_o,
  output logic                  dmem_req_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_req_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_req_data_o,
  output logic [3:0]            dmem_req_mask_o,
  input  logic                  dmem_req_ready_i,
  input  logic                  dmem_resp_v_i,
  input  logic [DATA_WIDTH-1:0] dmem_resp_data_i,
  output logic                  stall_o,
  output logic                  load_v_o,
  output logic [DATA_WIDTH-1:0] load_data_o,
  output logic                  misalign_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            mask_q, mask_d;
  logic                  we_q, we_d;
  logic                  byte_q, byte_d;
  logic [DATA_WIDTH-1:0] load_data_q, load_data_d;

  logic                  misalign;
  logic                  start;
  logic                  reqActive;
  logic [7:0]            respByte;

  // Word accesses must be naturally aligned; byte accesses never misalign.
  assign misalign  = ~is_byte_op_i & (addr_i[1:0] != 2'b00);
  // Both load and store asserted is treated as a store via is_store_op_i below.
  assign start     = (state_q == IDLE) & valid_i & is_mem_op_i &
                     (is_load_op_i | is_store_op_i) & ~misalign;
  assign reqActive = (state_q == REQ);

  // Select the addressed byte lane of the read response (lane 0 = bits 7:0).
  always_comb begin
    respByte = dmem_resp_data_i[7:0];
    case (addr_q[1:0])
      2'd0:    respByte = dmem_resp_data_i[7:0];
      2'd1:    respByte = dmem_resp_data_i[15:8];
      2'd2:    respByte = dmem_resp_data_i[23:16];
      default: respByte = dmem_resp_data_i[31:24];
    endcase
  end

  // Transaction sequencing plus capture of the request and the load result.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    we_d        = we_q;
    byte_d      = byte_q;
    load_data_d = load_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = REQ;
          addr_d  = addr_i;
          we_d    = is_store_op_i;
          byte_d  = is_byte_op_i;
          if (!is_store_op_i) begin
            mask_d  = 4'h0;
            wdata_d = '0;
          end else if (is_byte_op_i) begin
            mask_d  = 4'b0001 << addr_i[1:0];
            wdata_d = {4{store_data_i[7:0]}};
          end else begin
            mask_d  = 4'hF;
            wdata_d = store_data_i;
          end
        end
      end
      REQ: begin
        if (dmem_req_ready_i) begin
          state_d = we_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (dmem_resp_v_i) begin
          state_d     = DONE;
          load_data_d = byte_q ? {{(DATA_WIDTH-8){1'b0}}, respByte} : dmem_resp_data_i;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset abandons any outstanding access and clears the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= 4'h0;
      we_q        <= 1'b0;
      byte_q      <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      we_q        <= we_d;
      byte_q      <= byte_d;
      load_data_q <= load_data_d;
    end
  end

  assign dmem_req_v_o    = reqActive;
  assign dmem_req_we_o   = reqActive & we_q;
  assign dmem_req_addr_o = reqActive ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign dmem_req_data_o = reqActive ? wdata_q : '0;
  assign dmem_req_mask_o = reqActive ? mask_q : 4'h0;

  // Stall is combinational in IDLE so the issuing instruction is held at once.
  assign stall_o     = start | reqActive | (state_q == WAIT);
  assign load_v_o    = (state_q == DONE) & ~we_q;
  assign load_data_o = load_data_q;
  assign misalign_o  = (state_q == IDLE) & valid_i & is_mem_op_i & misalign;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: table-driven transactions with a
// load-data scoreboard, plus hand-written reset, misalign and ignore cases.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid, memOp, ldOp, stOp, byOp;
  logic [31:0] addr, sdata;
  logic        reqV, reqWe, ready, respV;
  logic [31:0] reqAddr, reqData, respData;
  logic [3:0]  reqMask;
  logic        stall, loadV, misal;
  logic [31:0] loadData;

  int errors = 0;
  int checks = 0;
  logic [31:0] lastLoad = 32'h0;
  logic [31:0] sb[$];

  typedef struct {
    logic        ld, st, by;
    logic [31:0] addr, sdata, resp;
    int          readyDelay, respDelay;
    logic [31:0] expAddr, expData;
    logic [3:0]  expMask;
    logic        expWe;
    logic [31:0] expLoad;
    int          expStall;
    logic        holdInDone;
  } vec_t;

  vec_t vecs[9];

  mem_stage_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .valid_i(valid), .is_mem_op_i(memOp), .is_load_op_i(ldOp),
    .is_store_op_i(stOp), .is_byte_op_i(byOp),
    .addr_i(addr), .store_data_i(sdata),
    .dmem_req_v_o(reqV), .dmem_req_we_o(reqWe), .dmem_req_addr_o(reqAddr),
    .dmem_req_data_o(reqData), .dmem_req_mask_o(reqMask),
    .dmem_req_ready_i(ready), .dmem_resp_v_i(respV), .dmem_resp_data_i(respData),
    .stall_o(stall), .load_v_o(loadV), .load_data_o(loadData), .misalign_o(misal)
  );

  always #5 clk = ~clk;

  // Hard stop in case something hangs outside the bounded loops.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input logic ld, st, by, input logic [31:0] a, d, r,
                              input int rdy, rsp, input logic [31:0] eAddr, eData,
                              input logic [3:0] eMask, input logic eWe,
                              input logic [31:0] eLoad, input int eStall, input logic hold);
    vec_t v;
    v.ld = ld; v.st = st; v.by = by; v.addr = a; v.sdata = d; v.resp = r;
    v.readyDelay = rdy; v.respDelay = rsp; v.expAddr = eAddr; v.expData = eData;
    v.expMask = eMask; v.expWe = eWe; v.expLoad = eLoad; v.expStall = eStall;
    v.holdInDone = hold;
    return v;
  endfunction

  task automatic idleInputs();
    valid = 0; memOp = 0; ldOp = 0; stOp = 0; byOp = 0;
    addr = 0; sdata = 0; ready = 0; respV = 0; respData = 0;
  endtask

  // Runs one complete transaction; noise responses are driven while the request is pending.
  task automatic applyStimulus(input vec_t v);
    int  reqSeen = 0;
    int  sinceAcc = 0;
    int  stallCycles = 0;
    bit  accepted = 0;
    bit  doneSeen = 0;
    bit  isLoad;
    logic [31:0] exp;
    isLoad = v.ld & ~v.st;
    if (isLoad) sb.push_back(v.expLoad);
    for (int c = 0; c < 40 && !doneSeen; c++) begin
      @(negedge clk);
      valid = (c == 0) || (v.holdInDone && c == v.expStall);
      memOp = valid; ldOp = v.ld; stOp = v.st; byOp = v.by;
      addr = v.addr; sdata = v.sdata;
      ready = (reqSeen >= v.readyDelay);
      if (accepted) sinceAcc++;
      if (!accepted && c > 0) begin
        respV = 1; respData = 32'hFFFF_FFFF;
      end else if (accepted && isLoad && sinceAcc == v.respDelay) begin
        respV = 1; respData = v.resp;
      end else begin
        respV = 0; respData = 32'h0;
      end
      #1;
      if (c == 0) begin
        checkOutput("stall at issue", stall, 1);
        checkOutput("misalign at issue", misal, 0);
      end
      if (stall) stallCycles++;
      else if (c > 0) doneSeen = 1;
      if (reqV) begin
        checkOutput("req addr", reqAddr, v.expAddr);
        checkOutput("req we", reqWe, v.expWe);
        if (v.expWe) begin
          checkOutput("req mask", reqMask, v.expMask);
          checkOutput("req data", reqData, v.expData);
        end
        reqSeen++;
        if (ready) accepted = 1;
      end else begin
        checkOutput("idle req bus", reqAddr | reqData | {28'h0, reqMask} | {31'h0, reqWe}, 0);
      end
      if (loadV) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected load_v", loadV, 0);
        end else begin
          exp = sb.pop_front();
          checkOutput("load data", loadData, exp);
          lastLoad = exp;
        end
      end
      if (doneSeen) begin
        checkOutput("load_v in DONE", loadV, isLoad);
        checkOutput("load data held", loadData, lastLoad);
      end
    end
    if (!doneSeen) checkOutput("transaction timeout", 0, 1);
    checkOutput("stall cycles", stallCycles, v.expStall);
    checkOutput("request cycles", reqSeen, v.readyDelay + 1);
    checkOutput("scoreboard drained", sb.size(), 0);
  endtask

  initial begin
    //           ld st by addr        sdata         resp          rdy rsp expAddr     expData       mask   we  expLoad       stall hold
    vecs[0] = mk(0, 1, 0, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 32'h100, 32'hDEADBEEF, 4'hF, 1, 32'h0,        2, 0);
    vecs[1] = mk(0, 1, 1, 32'h203, 32'h000000A5, 32'h0,        3, 0, 32'h200, 32'hA5A5A5A5, 4'h8, 1, 32'h0,        5, 0);
    vecs[2] = mk(1, 0, 1, 32'h402, 32'h0,        32'h11223344, 0, 2, 32'h400, 32'h0,        4'h0, 0, 32'h00000022, 4, 0);
    vecs[3] = mk(1, 0, 0, 32'h010, 32'h0,        32'h12345678, 0, 1, 32'h010, 32'h0,        4'h0, 0, 32'h12345678, 3, 1);
    vecs[4] = mk(0, 1, 0, 32'h014, 32'hCAFEF00D, 32'h0,        1, 0, 32'h014, 32'hCAFEF00D, 4'hF, 1, 32'h0,        3, 0);
    vecs[5] = mk(1, 0, 1, 32'h007, 32'h0,        32'hAABBCCDD, 1, 1, 32'h004, 32'h0,        4'h0, 0, 32'h000000AA, 4, 0);
    vecs[6] = mk(0, 1, 1, 32'h001, 32'h12345677, 32'h0,        0, 0, 32'h000, 32'h77777777, 4'h2, 1, 32'h0,        2, 0);
    vecs[7] = mk(1, 1, 0, 32'h030, 32'h0BADF00D, 32'h0,        0, 0, 32'h030, 32'h0BADF00D, 4'hF, 1, 32'h0,        2, 0);
    vecs[8] = mk(1, 0, 0, 32'h03C, 32'h0,        32'h89ABCDEF, 2, 3, 32'h03C, 32'h0,        4'h0, 0, 32'h89ABCDEF, 7, 0);

    idleInputs();
    reset = 1;
    valid = 1; memOp = 1; ldOp = 1; addr = 32'h100; respV = 1; respData = 32'h5A5A5A5A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("reset req_v", reqV, 0);
    checkOutput("reset stall", stall, 0);
    checkOutput("reset load_v", loadV, 0);
    checkOutput("reset load_data", loadData, 0);
    checkOutput("reset req bus", reqAddr | reqData | {28'h0, reqMask} | {31'h0, reqWe}, 0);
    reset = 0;
    @(negedge clk);
    #1;
    checkOutput("after reset stall", stall, 0);
    checkOutput("after reset misalign", misal, 0);

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    // Misaligned word load is flagged and dropped.
    @(negedge clk);
    idleInputs();
    valid = 1; memOp = 1; ldOp = 1; addr = 32'h406; ready = 1;
    #1;
    checkOutput("misalign flag", misal, 1);
    checkOutput("misalign stall", stall, 0);
    checkOutput("misalign req_v", reqV, 0);
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("misalign no request", reqV, 0);
    checkOutput("misalign no stall", stall, 0);

    // Memory op with neither load nor store is ignored.
    @(negedge clk);
    valid = 1; memOp = 1; addr = 32'h50; ready = 1;
    #1;
    checkOutput("ignored op stall", stall, 0);
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("ignored op req_v", reqV, 0);
    checkOutput("load data kept", loadData, lastLoad);

    // Reset during WAIT abandons the load; the late response is ignored.
    @(negedge clk);
    valid = 1; memOp = 1; ldOp = 1; addr = 32'h20; ready = 1;
    #1;
    checkOutput("rst-wait issue stall", stall, 1);
    @(negedge clk);
    idleInputs();
    ready = 1;
    #1;
    checkOutput("rst-wait in REQ", reqV, 1);
    @(negedge clk);
    ready = 0;
    #1;
    checkOutput("rst-wait in WAIT stall", stall, 1);
    checkOutput("rst-wait in WAIT req_v", reqV, 0);
    reset = 1;
    @(negedge clk);
    reset = 0;
    respV = 1; respData = 32'h55555555;
    #1;
    checkOutput("rst-wait stall", stall, 0);
    checkOutput("rst-wait load_v", loadV, 0);
    checkOutput("rst-wait load_data", loadData, 0);
    @(negedge clk);
    respV = 0; respData = 0;
    #1;
    checkOutput("rst-wait late load_v", loadV, 0);
    checkOutput("rst-wait late load_data", loadData, 0);
    checkOutput("rst-wait late req_v", reqV, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
